alu_issue_ctrl: RTL and testbench

Issue controller for the shared integer ALU in the Tomasulo core. Arbitrates round-robin among the ALU reservation-station entries whose operands are ready. Sequences the single-cycle ops (add/and/or) and the two-cycle subtract on the ALU datapath. Holds each tagged result until the common data bus (CDB) arbiter grants broadcast. It sits between the ALU reservation station and the CDB arbiter.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/rr_picker.sv | 31 +++
 rtl/alu_issue_ctrl.sv | 115 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op and state encodings plus default widths for the shared ALU issue path
package alu_pkg;
  localparam int ALU_NRS     = 3;
  localparam int ALU_DATA_W  = 32;
  localparam int ALU_LABEL_W = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_INV  = 2'b01,
    S_EXEC = 2'b10,
    S_DONE = 2'b11
  } state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first request after the pointer
module rr_picker
  import alu_pkg::*;
#(
  parameter int NRS = ALU_NRS,
  parameter int IW  = (NRS > 1) ? $clog2(NRS) : 1
) (
  input  logic [NRS-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NRS-1:0] onehot,
  output logic [IW-1:0]  index,
  output logic           anyReq
);
  localparam logic [IW:0] N   = (IW+1)'(NRS);
  localparam logic [IW:0] ONE = (IW+1)'(1);
  logic [2*NRS-1:0] dbl;
  logic [NRS-1:0]   rot;
  logic [IW-1:0]    off;
  logic [IW:0]      sum;
  assign anyReq = |req;
  // rotate so the entry after the pointer sits at bit 0, take the lowest set bit, map back
  always_comb begin
    dbl = {req, req} >> ({1'b0, ptr} + ONE);
    rot = dbl[NRS-1:0];
    off = '0;
    for (int k = NRS - 1; k >= 0; k--) if (rot[k]) off = IW'(k);
    sum = {1'b0, ptr} + {1'b0, off} + ONE;
    index = (sum >= N) ? IW'(sum - N) : IW'(sum);
    onehot = anyReq ? NRS'(1) << index : '0;
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: round-robin issue of ready RS entries to the shared ALU, result held until CDB grant
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NRS     = ALU_NRS,
  parameter int DATA_W  = ALU_DATA_W,
  parameter int LABEL_W = ALU_LABEL_W
) (
  input  logic                   clk,
  input  logic                   nRST,
  input  logic [NRS-1:0]         reqValid,
  input  logic [2*NRS-1:0]       reqOp,
  input  logic [DATA_W*NRS-1:0]  reqData1,
  input  logic [DATA_W*NRS-1:0]  reqData2,
  input  logic [LABEL_W*NRS-1:0] reqLabel,
  output logic [NRS-1:0]         grant,
  output logic                   busy,
  output logic                   cdbReq,
  input  logic                   cdbGrant,
  output logic [DATA_W-1:0]      cdbData,
  output logic [LABEL_W-1:0]     cdbLabel
);
  localparam int IW = (NRS > 1) ? $clog2(NRS) : 1;
  state_t             state;
  alu_op_t            op;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      idx;
  logic [DATA_W-1:0]  a;
  logic [DATA_W-1:0]  b;
  logic [DATA_W-1:0]  res;
  logic               cin;
  logic [LABEL_W-1:0] tag;
  logic [NRS-1:0]     win;
  logic               any;
  logic               issue;
  logic [1:0]         ops [NRS];
  logic [DATA_W-1:0]  d1  [NRS];
  logic [DATA_W-1:0]  d2  [NRS];
  logic [LABEL_W-1:0] lb  [NRS];

  for (genvar i = 0; i < NRS; i++) begin : g_unpack
    assign ops[i] = reqOp[2*i +: 2];
    assign d1[i]  = reqData1[DATA_W*i +: DATA_W];
    assign d2[i]  = reqData2[DATA_W*i +: DATA_W];
    assign lb[i]  = reqLabel[LABEL_W*i +: LABEL_W];
  end

  rr_picker #(.NRS(NRS), .IW(IW)) u_pick (
    .req   (reqValid),
    .ptr   (ptr),
    .onehot(win),
    .index (idx),
    .anyReq(any)
  );

  // issue whenever the datapath is free: idle, or the held result leaves on the CDB this cycle
  always_comb begin
    issue = any && (state == S_IDLE || (state == S_DONE && cdbGrant));
    grant = issue ? win : '0;
  end

  // add and subtract share one adder; subtract arrives here with B already inverted and carry-in set
  always_comb begin
    res = (op == ALU_AND) ? a & b : (op == ALU_OR) ? a | b : a + b + DATA_W'(cin);
  end

  // controller FSM with operand latches and the registered CDB outputs
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state    <= S_IDLE;
      ptr      <= IW'(NRS - 1);
      a        <= '0;
      b        <= '0;
      cin      <= 1'b0;
      op       <= ALU_ADD;
      tag      <= '0;
      busy     <= 1'b0;
      cdbReq   <= 1'b0;
      cdbData  <= '0;
      cdbLabel <= '0;
    end else if (issue) begin
      ptr    <= idx;
      a      <= d1[idx];
      b      <= d2[idx];
      cin    <= 1'b0;
      op     <= alu_op_t'(ops[idx]);
      tag    <= lb[idx];
      busy   <= 1'b1;
      cdbReq <= 1'b0;
      state  <= (alu_op_t'(ops[idx]) == ALU_SUB) ? S_INV : S_EXEC;
    end else begin
      case (state)
        S_INV: begin
          b     <= ~b;
          cin   <= 1'b1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          cdbData  <= res;
          cdbLabel <= tag;
          cdbReq   <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          if (cdbGrant) begin
            cdbReq <= 1'b0;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for the ALU issue controller
module tb_alu_issue_ctrl;
  localparam int NRS = 3;
  localparam int DW  = 32;
  localparam int LW  = 4;

  logic              clk = 1'b0;
  logic              nRST = 1'b0;
  logic [NRS-1:0]    reqValid = '0;
  logic [2*NRS-1:0]  reqOp = '0;
  logic [DW*NRS-1:0] reqData1 = '0;
  logic [DW*NRS-1:0] reqData2 = '0;
  logic [LW*NRS-1:0] reqLabel = '0;
  logic [NRS-1:0]    grant;
  logic              busy;
  logic              cdbReq;
  logic              cdbGrant = 1'b0;
  logic [DW-1:0]     cdbData;
  logic [LW-1:0]     cdbLabel;

  int compared = 0;
  int mismatched = 0;
  logic [DW+LW-1:0] sb[$];
  logic [DW+LW-1:0] exp_r;

  alu_issue_ctrl #(.NRS(NRS), .DATA_W(DW), .LABEL_W(LW)) dut (
    .clk     (clk),
    .nRST    (nRST),
    .reqValid(reqValid),
    .reqOp   (reqOp),
    .reqData1(reqData1),
    .reqData2(reqData2),
    .reqLabel(reqLabel),
    .grant   (grant),
    .busy    (busy),
    .cdbReq  (cdbReq),
    .cdbGrant(cdbGrant),
    .cdbData (cdbData),
    .cdbLabel(cdbLabel)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (nRST && cdbReq && cdbGrant) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL cdb_unexpected got %h/%h expected no broadcast", cdbData, cdbLabel);
      end else begin
        exp_r = sb.pop_front();
        if ({cdbData, cdbLabel} !== exp_r) begin
          mismatched++;
          $display("FAIL cdb_result got %h/%h expected %h/%h", cdbData, cdbLabel, exp_r[DW+LW-1:LW], exp_r[LW-1:0]);
        end
      end
    end
  end

  function automatic logic [DW-1:0] model(input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
    return (op == 2'b00) ? x + y : (op == 2'b01) ? x - y : (op == 2'b10) ? x & y : x | y;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int e, input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [LW-1:0] t);
    reqOp[2*e +: 2] = op;
    reqData1[DW*e +: DW] = x;
    reqData2[DW*e +: DW] = y;
    reqLabel[LW*e +: LW] = t;
  endtask

  task automatic do_reset;
    nRST = 1'b0;
    step;
    step;
    nRST = 1'b1;
    step;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (!cdbReq && n < 10) begin
      step;
      n++;
    end
    compared++;
    if (n >= 10) begin
      mismatched++;
      $display("FAIL drain_timeout got cdbReq=%b expected 1 within 10 cycles", cdbReq);
    end
    cdbGrant = 1'b1;
    step;
    cdbGrant = 1'b0;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    step;
    compared++;
    if (grant !== '0 || busy !== 1'b0 || cdbReq !== 1'b0 || cdbData !== '0 || cdbLabel !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs got g=%b busy=%b req=%b d=%h l=%h expected all 0", grant, busy, cdbReq, cdbData, cdbLabel);
    end
    nRST = 1'b1;
    step;
  endtask

  task automatic test_op(input int e, input logic [1:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [LW-1:0] t);
    int n;
    logic [NRS-1:0] oh;
    oh = NRS'(1) << e;
    set_entry(e, op, x, y, t);
    reqValid = oh;
    #1;
    compared++;
    if (grant !== oh) begin
      mismatched++;
      $display("FAIL op_grant got %b expected %b", grant, oh);
    end
    sb.push_back({model(op, x, y), t});
    step;
    compared++;
    if (grant !== '0) begin
      mismatched++;
      $display("FAIL op_grant_pulse got %b expected 000", grant);
    end
    reqValid = '0;
    set_entry(e, ~op, ~x, ~y, ~t);
    n = 0;
    while (!cdbReq && n < 10) begin
      step;
      n++;
    end
    compared++;
    if (n !== ((op == 2'b01) ? 2 : 1)) begin
      mismatched++;
      $display("FAIL op_latency got %0d expected %0d", n, (op == 2'b01) ? 2 : 1);
    end
    cdbGrant = 1'b1;
    step;
    cdbGrant = 1'b0;
    compared++;
    if (busy !== 1'b0 || cdbReq !== 1'b0) begin
      mismatched++;
      $display("FAIL op_idle got busy=%b req=%b expected 0/0", busy, cdbReq);
    end
  endtask

  task automatic test_round_robin;
    int e;
    int n;
    logic [NRS-1:0] exp_g;
    do_reset;
    for (int i = 0; i < NRS; i++) set_entry(i, 2'b00, 32'(100 * (i + 1)), 32'(i + 1), LW'(i + 8));
    cdbGrant = 1'b1;
    reqValid = '1;
    #1;
    for (int k = 0; k < 4; k++) begin
      e = k % NRS;
      exp_g = NRS'(1) << e;
      n = 0;
      while (grant === '0 && n < 10) begin
        step;
        n++;
      end
      compared++;
      if (grant !== exp_g) begin
        mismatched++;
        $display("FAIL rr_order got %b expected %b", grant, exp_g);
      end
      if (k > 0) begin
        compared++;
        if (n !== 1) begin
          mismatched++;
          $display("FAIL rr_gap got %0d expected 1", n);
        end
      end
      sb.push_back({model(2'b00, 32'(100 * (e + 1)), 32'(e + 1)), LW'(e + 8)});
      step;
    end
    reqValid = '0;
    n = 0;
    while (busy && n < 10) begin
      step;
      n++;
    end
    cdbGrant = 1'b0;
    compared++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rr_drain got pending=%0d busy=%b expected 0/0", sb.size(), busy);
    end
  endtask

  task automatic test_backpressure;
    int n;
    set_entry(0, 2'b11, 32'h1234_0000, 32'h0000_5678, 4'h6);
    set_entry(1, 2'b01, 32'd50, 32'd8, 4'h9);
    reqValid = 3'b001;
    #1;
    sb.push_back({32'h1234_5678, 4'h6});
    step;
    reqValid = 3'b010;
    n = 0;
    while (!cdbReq && n < 10) begin
      step;
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      compared++;
      if (grant !== '0 || cdbReq !== 1'b1 || cdbData !== 32'h1234_5678 || cdbLabel !== 4'h6) begin
        mismatched++;
        $display("FAIL bp_hold got g=%b req=%b d=%h l=%h expected 000/1/12345678/6", grant, cdbReq, cdbData, cdbLabel);
      end
      step;
    end
    cdbGrant = 1'b1;
    #1;
    compared++;
    if (grant !== 3'b010) begin
      mismatched++;
      $display("FAIL bp_b2b_grant got %b expected 010", grant);
    end
    sb.push_back({32'd42, 4'h9});
    step;
    cdbGrant = 1'b0;
    reqValid = '0;
    compared++;
    if (cdbReq !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_b2b_busy got req=%b busy=%b expected 0/1", cdbReq, busy);
    end
    drain;
  endtask

  task automatic test_reset_mid_sub;
    set_entry(2, 2'b01, 32'd9, 32'd1, 4'hC);
    reqValid = 3'b100;
    #1;
    compared++;
    if (grant !== 3'b100) begin
      mismatched++;
      $display("FAIL rst_sub_grant got %b expected 100", grant);
    end
    step;
    reqValid = '0;
    compared++;
    if (busy !== 1'b1 || cdbReq !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_sub_inv got busy=%b req=%b expected 1/0", busy, cdbReq);
    end
    nRST = 1'b0;
    #1;
    compared++;
    if (grant !== '0 || busy !== 1'b0 || cdbReq !== 1'b0 || cdbData !== '0 || cdbLabel !== '0) begin
      mismatched++;
      $display("FAIL rst_async got g=%b busy=%b req=%b d=%h l=%h expected all 0", grant, busy, cdbReq, cdbData, cdbLabel);
    end
    step;
    nRST = 1'b1;
    step;
    step;
    compared++;
    if (cdbReq !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_dropped got req=%b busy=%b expected 0/0", cdbReq, busy);
    end
    set_entry(0, 2'b10, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h1);
    set_entry(1, 2'b00, 32'd1, 32'd1, 4'h2);
    reqValid = 3'b111;
    #1;
    compared++;
    if (grant !== 3'b001) begin
      mismatched++;
      $display("FAIL rst_ptr got %b expected 001", grant);
    end
    sb.push_back({32'h00F0_000F, 4'h1});
    step;
    reqValid = '0;
    drain;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL rst_pending got %0d expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_op(0, 2'b00, 32'd5, 32'd7, 4'd3);
    test_op(1, 2'b01, 32'd3, 32'd5, 4'd5);
    test_op(1, 2'b01, 32'd10, 32'd4, 4'd6);
    test_op(2, 2'b10, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'd7);
    test_op(0, 2'b11, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'd8);
    test_op(2, 2'b00, 32'hFFFF_FFFF, 32'd1, 4'd15);
    test_round_robin;
    test_backpressure;
    test_reset_mid_sub;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
